param_memory_ctrl: RTL and testbench
====================================

# param_memory_ctrl

Parametrised single-port synchronous memory controller that succeeds the fixed 8x8 memory driver. It stores DEPTH words of DATA_WIDTH bits and accepts read/write requests through a select/ready handshake. Read data comes back registered with a valid strobe. On reset, or on request, a hardware clear sequencer writes CLEAR_VALUE to every location, so benches and upstream logic no longer need a manual zero-write sweep before first use.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH (derived, not overridable).
- CLEAR_VALUE, 0, value written to every word during a clear sweep (DATA_WIDTH bits).

Ports:
- i_clock  in  1  single clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_select  in  1  request valid.
- i_operation  in  1  1 = write, 0 = read.
- i_addr  in  ADDR_WIDTH  request address.
- i_data  in  DATA_WIDTH  write data.
- i_clear  in  1  pulse to start a clear sweep.
- o_ready  out  1  controller accepts a request this cycle.
- o_data  out  DATA_WIDTH  registered read data.
- o_valid  out  1  o_data updated by a read; high for exactly one cycle per read.
- o_init_done  out  1  at least one full clear sweep has completed since reset.

## Operation
- States: CLEAR and IDLE.
- Reset values: state CLEAR, sweep counter 0, o_ready 0, o_valid 0, o_data 0, o_init_done 0.
- CLEAR state:
  - Each cycle writes CLEAR_VALUE to mem[counter], then increments the counter.
  - After writing address DEPTH-1: counter wraps to 0, state goes to IDLE, o_ready goes to 1, o_init_done goes to 1.
  - i_select is ignored. No o_valid.
- IDLE state:
  - A request is accepted on a rising edge where i_select=1, o_ready=1 and i_clear=0.
  - Write: mem[i_addr] <= i_data. o_data is unchanged and o_valid stays 0.
  - Read: o_data <= mem[i_addr] and o_valid <= 1.
  - On any cycle with no accepted read, o_valid <= 0. o_data holds its last read value.
- i_clear is sampled in IDLE: state goes to CLEAR, counter to 0, o_ready to 0. o_init_done stays 1. Any o_valid in flight still completes.
- i_clear together with i_select: clear has priority. The request is dropped and memory is not written.
- i_clear in CLEAR state: ignored; the sweep continues.
- i_reset has priority over everything. Reset mid-sweep restarts the sweep from address 0.
- Memory contents are not touched by i_reset itself; only the following sweep changes them.

## Timing
- Sweep length: exactly DEPTH cycles. o_ready rises after the DEPTH-th rising edge following the last edge with i_reset=1 (8 cycles at default parameters).
- Write latency: the data is stored at the accepting edge. A read of the same address accepted on the next edge returns the new data (no bypass needed, since the port is single).
- Read latency: 1 cycle. A read accepted at edge N drives o_data and o_valid=1 after edge N; o_valid clears after edge N+1 unless another read is accepted there.
- Throughput: one request per cycle. Back-to-back reads produce back-to-back o_valid pulses with no gap.
- o_ready is a registered state output with no combinational path from inputs.
- Address arithmetic: the sweep counter is ADDR_WIDTH bits and wraps modulo DEPTH. i_addr is always in range by construction.

## Test plan
- Reset then full read: release reset → o_ready stays 0 for exactly 8 cycles, then 1. Reads of addresses 0–7 return 0x00, each with a one-cycle o_valid, and o_init_done=1.
- Back-to-back writes: write 0x65, 0x6C, 0x69, 0x61, 0x73 to addresses 0–4 on consecutive cycles, idle 1 cycle, read addresses 0–4 back-to-back → the same values with o_valid high for 5 consecutive cycles. Address 5 reads 0x00.
- Write-then-read: write 0x55 to address 1, read address 1 on the next cycle → o_data 0x55 one cycle later. A following idle cycle → o_valid 0 and o_data holds 0x55.
- Clear while loaded:
  - After the previous test, pulse i_clear → o_ready low for 8 cycles and all reads return 0x00.
  - i_clear together with a write of 0xAA to address 2 → address 2 reads 0x00.
  - i_clear during the sweep has no effect: o_ready still rises 8 cycles after the first i_clear.
- Reset mid-sweep: assert i_reset during sweep cycle 3 → o_ready rises 8 cycles after the new release. A read attempted while o_ready=0 produces no o_valid.
- Generic parameters (DATA_WIDTH=16, ADDR_WIDTH=4, CLEAR_VALUE=0xFFFF):
  - Sweep lasts 16 cycles.
  - Address 9 reads 0xFFFF.
  - Write 0xBEEF to address 15, then read it → 0xBEEF.

Source files
------------

// File: rtl/param_memory_ctrl.sv
// -----------------------------------------------------------------------------
// param_memory_ctrl
//
// Parametrised single-port synchronous memory controller. Holds DEPTH words of
// DATA_WIDTH bits behind a select/ready request handshake. Reads return
// registered data with a one-cycle valid strobe. A hardware clear sequencer
// writes CLEAR_VALUE to every word after reset and whenever i_clear is pulsed
// while idle, so no manual initialisation sweep is needed upstream.
//
// Parameters:
//   DATA_WIDTH   word width in bits
//   ADDR_WIDTH   address width, DEPTH = 2**ADDR_WIDTH (derived)
//   CLEAR_VALUE  value written to every word by a clear sweep
//
// Ports:
//   i_clock      single clock, all state changes on its rising edge
//   i_reset      synchronous active-high reset, highest priority
//   i_select     request valid
//   i_operation  1 = write, 0 = read
//   i_addr       request address
//   i_data       write data
//   i_clear      pulse to start a clear sweep (honoured only while idle)
//   o_ready      a request is accepted this cycle (registered)
//   o_data       registered read data, holds its last read value
//   o_valid      one-cycle strobe per completed read
//   o_init_done  at least one full clear sweep has finished since reset
// -----------------------------------------------------------------------------
module param_memory_ctrl #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 3,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_select,
   input  logic                  i_operation,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_clear,
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_init_done
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Last address of the sweep; the counter wraps to zero right after it.
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   // Storage array; deliberately not reset, only the clear sweep initialises it.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   state_t                state_q,     state_d;
   logic [ADDR_WIDTH-1:0] cnt_q,       cnt_d;
   logic                  ready_q,     ready_d;
   logic                  valid_q,     valid_d;
   logic [DATA_WIDTH-1:0] data_q,      data_d;
   logic                  init_done_q, init_done_d;

   // Single memory write port shared by the sweep and accepted write requests.
   logic                  mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_waddr_s;
   logic [DATA_WIDTH-1:0] mem_wdata_s;

   // Next-state, output and memory-write decode for the CLEAR/IDLE controller.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ready_d     = ready_q;
      valid_d     = 1'b0;          // strobe drops unless a read is accepted
      data_d      = data_q;        // read data holds between reads
      init_done_d = init_done_q;
      mem_we_s    = 1'b0;
      mem_waddr_s = cnt_q;
      mem_wdata_s = CLEAR_VALUE;

      if (i_reset) begin
         // Reset must not disturb the array; the register update is handled
         // in the sequential block, so only the write is suppressed here.
         mem_we_s = 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               // i_select and i_clear are both ignored while sweeping.
               mem_we_s    = 1'b1;
               mem_waddr_s = cnt_q;
               mem_wdata_s = CLEAR_VALUE;
               if (cnt_q == LAST_ADDR) begin
                  cnt_d       = ADDR_ZERO;
                  state_d     = ST_IDLE;
                  ready_d     = 1'b1;
                  init_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + ADDR_ONE;
               end
            end

            ST_IDLE: begin
               if (i_clear) begin
                  // Clear wins over a simultaneous request, which is dropped.
                  state_d = ST_CLEAR;
                  cnt_d   = ADDR_ZERO;
                  ready_d = 1'b0;
               end else if (i_select && ready_q) begin
                  if (i_operation) begin
                     mem_we_s    = 1'b1;
                     mem_waddr_s = i_addr;
                     mem_wdata_s = i_data;
                  end else begin
                     data_d  = mem_q[i_addr];
                     valid_d = 1'b1;
                  end
               end else begin
                  mem_we_s = 1'b0;
               end
            end

            default: begin
               // Recover an illegal encoding by restarting a full sweep.
               state_d = ST_CLEAR;
               cnt_d   = ADDR_ZERO;
               ready_d = 1'b0;
            end
         endcase
      end
   end

   // Controller state and registered outputs, synchronous active-high reset.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q     <= ST_CLEAR;
         cnt_q       <= ADDR_ZERO;
         ready_q     <= 1'b0;
         valid_q     <= 1'b0;
         data_q      <= {DATA_WIDTH{1'b0}};
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         init_done_q <= init_done_d;
      end
   end

   // Memory array write port.
   always_ff @(posedge i_clock) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= mem_wdata_s;
      end
   end

   assign o_ready     = ready_q;
   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_init_done = init_done_q;

endmodule

// File: tb/tb_param_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_param_memory_ctrl
//
// Directed bench for param_memory_ctrl. Instance dut_a uses default parameters
// and is compared every cycle against a behavioural model (sweep as a
// remaining-cycle count, memory as a plain array filled when a sweep ends),
// plus literal expectations along the directed sequence. Instance dut_b uses
// DATA_WIDTH=16, ADDR_WIDTH=4, CLEAR_VALUE=16'hFFFF and is checked against
// literal values only.
// -----------------------------------------------------------------------------
module tb_param_memory_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- default-parameter instance ----------------
   logic       a_reset = 1'b1;
   logic       a_select = 1'b0;
   logic       a_op = 1'b0;
   logic [2:0] a_addr = 3'd0;
   logic [7:0] a_wdata = 8'h00;
   logic       a_clear = 1'b0;
   logic       a_ready;
   logic [7:0] a_data;
   logic       a_valid;
   logic       a_init;

   param_memory_ctrl dut_a (
      .i_clock(clk), .i_reset(a_reset), .i_select(a_select),
      .i_operation(a_op), .i_addr(a_addr), .i_data(a_wdata),
      .i_clear(a_clear), .o_ready(a_ready), .o_data(a_data),
      .o_valid(a_valid), .o_init_done(a_init)
   );

   // ---------------- generic-parameter instance ----------------
   logic        b_reset = 1'b1;
   logic        b_select = 1'b0;
   logic        b_op = 1'b0;
   logic [3:0]  b_addr = 4'd0;
   logic [15:0] b_wdata = 16'h0000;
   logic        b_clear = 1'b0;
   logic        b_ready;
   logic [15:0] b_data;
   logic        b_valid;
   logic        b_init;

   param_memory_ctrl #(
      .DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_VALUE(16'hFFFF)
   ) dut_b (
      .i_clock(clk), .i_reset(b_reset), .i_select(b_select),
      .i_operation(b_op), .i_addr(b_addr), .i_data(b_wdata),
      .i_clear(b_clear), .o_ready(b_ready), .o_data(b_data),
      .o_valid(b_valid), .o_init_done(b_init)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of dut_a ----------------
   int         m_left;        // sweep cycles still to run, 0 = idle
   logic [7:0] m_mem [8];
   logic       m_valid, m_init;
   logic [7:0] m_data;
   bit         chk_en = 1'b0;

   always @(posedge clk) begin
      if (a_reset) begin
         m_left = 8; m_valid = 1'b0; m_data = 8'h00; m_init = 1'b0;
      end else if (m_left > 0) begin
         m_valid = 1'b0;
         m_left--;
         if (m_left == 0) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_init = 1'b1;
         end
      end else begin
         m_valid = 1'b0;
         if (a_clear) m_left = 8;
         else if (a_select) begin
            if (a_op) m_mem[a_addr] = a_wdata;
            else begin
               m_data = m_mem[a_addr];
               m_valid = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_ready", {31'd0, a_ready}, {31'd0, (m_left == 0)});
         chk("model_valid", {31'd0, a_valid}, {31'd0, m_valid});
         chk("model_data",  {24'd0, a_data},  {24'd0, m_data});
         chk("model_init",  {31'd0, a_init},  {31'd0, m_init});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_read_chk(input logic [2:0] addr, input logic [7:0] exp);
      a_select = 1'b1; a_op = 1'b0; a_addr = addr;
      step();
      chk("a_read_valid", {31'd0, a_valid}, 32'd1);
      chk("a_read_data",  {24'd0, a_data},  {24'd0, exp});
   endtask

   task automatic a_write(input logic [2:0] addr, input logic [7:0] val);
      a_select = 1'b1; a_op = 1'b1; a_addr = addr; a_wdata = val;
      step();
   endtask

   task automatic a_idle();
      a_select = 1'b0; a_op = 1'b0; a_clear = 1'b0;
      step();
   endtask

   initial begin
      logic [7:0] pat [5];
      pat[0] = 8'h65; pat[1] = 8'h6C; pat[2] = 8'h69; pat[3] = 8'h61; pat[4] = 8'h73;

      // Reset then full read
      step(); step();
      chk_en = 1'b1;
      chk("rst_ready", {31'd0, a_ready}, 32'd0);
      chk("rst_valid", {31'd0, a_valid}, 32'd0);
      chk("rst_data",  {24'd0, a_data},  32'd0);
      chk("rst_init",  {31'd0, a_init},  32'd0);
      a_reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("sweep_ready", {31'd0, a_ready}, {31'd0, (k == 8)});
      end
      chk("init_done", {31'd0, a_init}, 32'd1);
      for (int a = 0; a < 8; a++) a_read_chk(3'(a), 8'h00);
      a_idle();
      chk("idle_valid", {31'd0, a_valid}, 32'd0);

      // Back-to-back writes then back-to-back reads
      for (int a = 0; a < 5; a++) a_write(3'(a), pat[a]);
      a_idle();
      for (int a = 0; a < 5; a++) a_read_chk(3'(a), pat[a]);
      a_read_chk(3'd5, 8'h00);

      // Write then read the same address on the next edge
      a_write(3'd1, 8'h55);
      a_read_chk(3'd1, 8'h55);
      a_idle();
      chk("hold_valid", {31'd0, a_valid}, 32'd0);
      chk("hold_data",  {24'd0, a_data},  32'h55);

      // Clear together with a write; second clear mid-sweep is ignored
      a_clear = 1'b1; a_select = 1'b1; a_op = 1'b1; a_addr = 3'd2; a_wdata = 8'hAA;
      step();
      chk("clr_ready0", {31'd0, a_ready}, 32'd0);
      a_clear = 1'b0; a_select = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         a_clear = (k == 3);
         step();
         chk("clr_ready", {31'd0, a_ready}, {31'd0, (k == 8)});
      end
      a_clear = 1'b0;
      chk("clr_init", {31'd0, a_init}, 32'd1);
      for (int a = 0; a < 8; a++) a_read_chk(3'(a), 8'h00);
      a_idle();

      // Reset mid-sweep, with a read attempted while not ready
      a_clear = 1'b1;
      step();
      a_clear = 1'b0; a_select = 1'b1; a_op = 1'b0; a_addr = 3'd3;
      step();
      chk("busy_valid", {31'd0, a_valid}, 32'd0);
      step();
      a_reset = 1'b1;
      step();
      chk("midrst_init", {31'd0, a_init}, 32'd0);
      a_reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("rst2_ready", {31'd0, a_ready}, {31'd0, (k == 8)});
         if (k < 8) chk("rst2_valid", {31'd0, a_valid}, 32'd0);
      end
      a_select = 1'b0;
      a_read_chk(3'd4, 8'h00);
      a_idle();
      chk_en = 1'b0;

      // Generic-parameter instance
      b_reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         chk("b_sweep_ready", {31'd0, b_ready}, {31'd0, (k == 16)});
      end
      chk("b_init", {31'd0, b_init}, 32'd1);
      b_select = 1'b1; b_op = 1'b0; b_addr = 4'd9;
      step();
      chk("b_read9_valid", {31'd0, b_valid}, 32'd1);
      chk("b_read9_data",  {16'd0, b_data},  32'hFFFF);
      b_op = 1'b1; b_addr = 4'd15; b_wdata = 16'hBEEF;
      step();
      chk("b_wr_valid", {31'd0, b_valid}, 32'd0);
      b_op = 1'b0;
      step();
      chk("b_read15_valid", {31'd0, b_valid}, 32'd1);
      chk("b_read15_data",  {16'd0, b_data},  32'hBEEF);
      b_select = 1'b0;
      step();
      chk("b_idle_valid", {31'd0, b_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
